// File: rtl/chimera_pkg.sv
// Shared types and defaults for the chimera cluster power sequencer.
// Holds the sequencer state encoding and its default timing constants.
package chimera_pkg;

   localparam int ExtClusters         = 5;
   localparam int PwrSeqRstCycles     = 8;
   localparam int PwrSeqTimeoutCycles = 1024;

   typedef enum logic [3:0] {
      IDLE,
      ISO_ON,
      CLK_OFF,
      RST,
      CLK_ON,
      RST_REL,
      ISO_OFF,
      DONE,
      ABORT
   } pwr_seq_state_e;

endpackage

// File: rtl/chimera_pwr_rr_pick.sv
// Combinational round-robin pick: first set bit of mask at or after ptr,
// wrapping modulo n. ptr is assumed to be below n.
module chimera_pwr_rr_pick #(
   parameter int N    = 5,
   parameter int IdxW = 3
) (
   input  logic [N-1:0]    mask,
   input  logic [IdxW-1:0] ptr,
   output logic            valid,
   output logic [IdxW-1:0] idx
);

   logic [IdxW:0] pos;

   // Scan offsets from farthest to nearest so the nearest eligible bit wins.
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         pos = {1'b0, ptr} + (IdxW+1)'(i);
         if (pos >= (IdxW+1)'(N)) begin
            pos = pos - (IdxW+1)'(N);
         end
         if (mask[pos[IdxW-1:0]]) begin
            valid = 1'b1;
            idx   = pos[IdxW-1:0];
         end
      end
   end

endmodule

// File: rtl/chimera_cluster_pwr_seq.sv
// Shared cluster power sequencer: one cluster at a time, isolation -> clock -> reset.
// Optional CHIMERA_PWR_SEQ_IRQ_EN adds done_irq_o / done_idx_o completion reporting.
module chimera_cluster_pwr_seq
   import chimera_pkg::*;
#(
   parameter int NumClusters   = ExtClusters,
   parameter int RstCycles     = PwrSeqRstCycles,
   parameter int TimeoutCycles = PwrSeqTimeoutCycles,
   parameter int CntWidth      = $clog2(TimeoutCycles + 1)
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NumClusters-1:0] pwr_req_i,
   output logic [NumClusters-1:0] pwr_state_o,
   output logic                   busy_o,
   output logic [NumClusters-1:0] err_o,
   input  logic [NumClusters-1:0] err_clr_i,
   output logic [NumClusters-1:0] iso_req_o,
   input  logic [NumClusters-1:0] iso_ack_i,
   output logic [NumClusters-1:0] clk_en_o,
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
   output logic                           done_irq_o,
   output logic [$clog2(NumClusters)-1:0] done_idx_o,
`endif
   output logic [NumClusters-1:0] cluster_rst_o
);

   localparam int IdxW = $clog2(NumClusters);

   pwr_seq_state_e         state_q, state_d;
   logic [IdxW-1:0]        cur_q, cur_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;
   logic                   dir_q, dir_d;
   logic [CntWidth-1:0]    cnt_q, cnt_d;
   logic [NumClusters-1:0] iso_q, iso_d;
   logic [NumClusters-1:0] clk_en_q, clk_en_d;
   logic [NumClusters-1:0] crst_q, crst_d;
   logic [NumClusters-1:0] pwr_q, pwr_d;
   logic [NumClusters-1:0] err_q, err_d;
   logic                   busy_q;

   logic [NumClusters-1:0] eligible;
   logic                   pick_valid;
   logic [IdxW-1:0]        pick_idx;
   logic [CntWidth-1:0]    cnt_inc;
   logic [IdxW-1:0]        ptr_adv;
   logic                   timed_out;
   logic                   rst_done;

   assign eligible  = (pwr_req_i ^ pwr_q) & ~err_q;
   assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CntWidth'(1);
   assign ptr_adv   = (cur_q == IdxW'(NumClusters - 1)) ? '0 : cur_q + IdxW'(1);
   assign timed_out = (cnt_q >= CntWidth'(TimeoutCycles));
   assign rst_done  = (cnt_q >= CntWidth'(RstCycles - 1));

   chimera_pwr_rr_pick #(
      .N    (NumClusters),
      .IdxW (IdxW)
   ) u_pick (
      .mask  (eligible),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         cur_q    <= '0;
         ptr_q    <= '0;
         dir_q    <= 1'b0;
         cnt_q    <= '0;
         iso_q    <= '0;
         clk_en_q <= '1;
         crst_q   <= '0;
         pwr_q    <= '1;
         err_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cur_q    <= cur_d;
         ptr_q    <= ptr_d;
         dir_q    <= dir_d;
         cnt_q    <= cnt_d;
         iso_q    <= iso_d;
         clk_en_q <= clk_en_d;
         crst_q   <= crst_d;
         pwr_q    <= pwr_d;
         err_q    <= err_d;
         busy_q   <= (state_d != IDLE);
      end
   end

   // Output vectors are next-stated here so every port comes straight from a flop.
   always_comb begin
      state_d  = state_q;
      cur_d    = cur_q;
      ptr_d    = ptr_q;
      dir_d    = dir_q;
      cnt_d    = cnt_q;
      iso_d    = iso_q;
      clk_en_d = clk_en_q;
      crst_d   = crst_q;
      pwr_d    = pwr_q;
      err_d    = err_q & ~err_clr_i;
      unique case (state_q)
         IDLE: begin
            if (pick_valid) begin
               cur_d = pick_idx;
               dir_d = pwr_req_i[pick_idx];
               cnt_d = '0;
               if (pwr_req_i[pick_idx]) begin
                  clk_en_d[pick_idx] = 1'b1;
                  state_d            = CLK_ON;
               end else begin
                  iso_d[pick_idx] = 1'b1;
                  state_d         = ISO_ON;
               end
            end
         end
         ISO_ON: begin
            if (iso_ack_i[cur_q]) begin
               clk_en_d[cur_q] = 1'b0;
               state_d         = CLK_OFF;
            end else if (timed_out) begin
               state_d = ABORT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         CLK_OFF: begin
            crst_d[cur_q] = 1'b1;
            cnt_d         = '0;
            state_d       = RST;
         end
         RST: begin
            if (rst_done) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         CLK_ON: begin
            cnt_d   = '0;
            state_d = RST_REL;
         end
         RST_REL: begin
            if (rst_done) begin
               crst_d[cur_q] = 1'b0;
               iso_d[cur_q]  = 1'b0;
               cnt_d         = '0;
               state_d       = ISO_OFF;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         ISO_OFF: begin
            if (!iso_ack_i[cur_q]) begin
               state_d = DONE;
            end else if (timed_out) begin
               state_d = ABORT;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: begin
            pwr_d[cur_q] = dir_q;
            ptr_d        = ptr_adv;
            state_d      = IDLE;
         end
         ABORT: begin
            // Put the cluster back exactly as it was before this request.
            err_d[cur_q] = 1'b1;
            if (dir_q) begin
               iso_d[cur_q]    = 1'b1;
               crst_d[cur_q]   = 1'b1;
               clk_en_d[cur_q] = 1'b0;
            end else begin
               iso_d[cur_q] = 1'b0;
            end
            ptr_d   = ptr_adv;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef CHIMERA_PWR_SEQ_IRQ_EN
   logic            irq_q;
   logic [IdxW-1:0] idx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         irq_q <= 1'b0;
         idx_q <= '0;
      end else begin
         irq_q <= (state_q == DONE) || (state_q == ABORT);
         if ((state_q == DONE) || (state_q == ABORT)) begin
            idx_q <= cur_q;
         end
      end
   end

   assign done_irq_o = irq_q;
   assign done_idx_o = idx_q;
`endif

   assign pwr_state_o   = pwr_q;
   assign busy_o        = busy_q;
   assign err_o         = err_q;
   assign iso_req_o     = iso_q;
   assign clk_en_o      = clk_en_q;
   assign cluster_rst_o = crst_q;

endmodule

// File: tb/tb_chimera_cluster_pwr_seq.sv
// Directed self-checking bench for chimera_cluster_pwr_seq (5 clusters, 8 reset
// cycles, 1024-cycle timeout); also covers CHIMERA_PWR_SEQ_IRQ_EN when defined.
module tb_chimera_cluster_pwr_seq;

   localparam int N = 5;

   logic         clk = 1'b0;
   logic         rst;
   logic [N-1:0] pwr_req;
   logic [N-1:0] pwr_state;
   logic         busy;
   logic [N-1:0] err;
   logic [N-1:0] err_clr;
   logic [N-1:0] iso_req;
   logic [N-1:0] iso_ack;
   logic [N-1:0] clk_en;
   logic [N-1:0] cluster_rst;
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
   logic         done_irq;
   logic [2:0]   done_idx;
`endif

   // Ack model: either follows iso_req (minus stuck lanes) or is driven by hand.
   logic         auto_ack;
   logic [N-1:0] stuck;
   logic [N-1:0] man_ack;
   assign iso_ack = auto_ack ? (iso_req & ~stuck) : man_ack;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   chimera_cluster_pwr_seq dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pwr_req_i     (pwr_req),
      .pwr_state_o   (pwr_state),
      .busy_o        (busy),
      .err_o         (err),
      .err_clr_i     (err_clr),
      .iso_req_o     (iso_req),
      .iso_ack_i     (iso_ack),
      .clk_en_o      (clk_en),
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
      .done_irq_o    (done_irq),
      .done_idx_o    (done_idx),
`endif
      .cluster_rst_o (cluster_rst)
   );

   task automatic do_reset();
      @(negedge clk);
      rst     = 1'b1;
      err_clr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      pwr_req  = '1;
      auto_ack = 1'b1;
      stuck    = '0;
      man_ack  = '0;
      do_reset();
      checks++; if (pwr_state !== 5'b11111) begin errors++; $display("FAIL reset_pwr_state got=%b exp=11111", pwr_state); end
      checks++; if (clk_en !== 5'b11111) begin errors++; $display("FAIL reset_clk_en got=%b exp=11111", clk_en); end
      checks++; if (iso_req !== 5'b00000) begin errors++; $display("FAIL reset_iso_req got=%b exp=00000", iso_req); end
      checks++; if (cluster_rst !== 5'b00000) begin errors++; $display("FAIL reset_cluster_rst got=%b exp=00000", cluster_rst); end
      checks++; if (err !== 5'b00000) begin errors++; $display("FAIL reset_err got=%b exp=00000", err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
      checks++; if (done_irq !== 1'b0 || done_idx !== 3'd0) begin errors++; $display("FAIL reset_irq got=%b/%0d exp=0/0", done_irq, done_idx); end
`endif
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_request_busy got=%b exp=0", busy); end
   endtask

   // Cluster 2 down with a hand-driven ack three cycles after iso_req rises.
   task automatic test_power_down();
      auto_ack = 1'b0;
      man_ack  = '0;
      pwr_req  = 5'b11011;
      @(negedge clk);
      checks++; if (iso_req !== 5'b00100 || busy !== 1'b1) begin errors++; $display("FAIL down_iso_req got=%b busy=%b exp=00100 busy=1", iso_req, busy); end
      repeat (2) @(negedge clk);
      checks++; if (clk_en !== 5'b11111) begin errors++; $display("FAIL down_wait_ack_clk_en got=%b exp=11111", clk_en); end
      man_ack = 5'b00100;
      @(negedge clk);
      checks++; if (clk_en !== 5'b11011 || cluster_rst !== 5'b00000) begin errors++; $display("FAIL down_clk_off got clk_en=%b rst=%b exp=11011/00000", clk_en, cluster_rst); end
      @(negedge clk);
      checks++; if (cluster_rst !== 5'b00100 || pwr_state !== 5'b11111) begin errors++; $display("FAIL down_rst_on got rst=%b pwr=%b exp=00100/11111", cluster_rst, pwr_state); end
      repeat (8) @(negedge clk);
      checks++; if (pwr_state !== 5'b11111 || busy !== 1'b1) begin errors++; $display("FAIL down_rst_hold got pwr=%b busy=%b exp=11111/1", pwr_state, busy); end
      @(negedge clk);
      checks++; if (pwr_state !== 5'b11011 || busy !== 1'b0) begin errors++; $display("FAIL down_done got pwr=%b busy=%b exp=11011/0", pwr_state, busy); end
      checks++; if (iso_req !== 5'b00100 || cluster_rst !== 5'b00100 || clk_en !== 5'b11011) begin errors++; $display("FAIL down_off_outputs got iso=%b rst=%b clk=%b exp=00100/00100/11011", iso_req, cluster_rst, clk_en); end
   endtask

   // Cluster 2 back up; ack held two cycles after iso_req drops.
   task automatic test_power_up();
      pwr_req = 5'b11111;
      @(negedge clk);
      checks++; if (clk_en !== 5'b11111 || cluster_rst !== 5'b00100 || iso_req !== 5'b00100) begin errors++; $display("FAIL up_clk_on got clk=%b rst=%b iso=%b exp=11111/00100/00100", clk_en, cluster_rst, iso_req); end
      repeat (8) @(negedge clk);
      checks++; if (cluster_rst !== 5'b00100) begin errors++; $display("FAIL up_rst_hold got=%b exp=00100", cluster_rst); end
      @(negedge clk);
      checks++; if (cluster_rst !== 5'b00000 || iso_req !== 5'b00000 || pwr_state !== 5'b11011) begin errors++; $display("FAIL up_rst_rel got rst=%b iso=%b pwr=%b exp=00000/00000/11011", cluster_rst, iso_req, pwr_state); end
      @(negedge clk);
      checks++; if (pwr_state !== 5'b11011 || busy !== 1'b1) begin errors++; $display("FAIL up_wait_ack got pwr=%b busy=%b exp=11011/1", pwr_state, busy); end
      man_ack = '0;
      @(negedge clk);
      checks++; if (pwr_state !== 5'b11011) begin errors++; $display("FAIL up_done_state got=%b exp=11011", pwr_state); end
      @(negedge clk);
      checks++; if (pwr_state !== 5'b11111 || busy !== 1'b0) begin errors++; $display("FAIL up_done got pwr=%b busy=%b exp=11111/0", pwr_state, busy); end
   endtask

   // All clusters requested off from reset: must go 0..4, one at a time.
   task automatic test_all_down();
      logic [2:0]   exp_q[$];
      logic [N-1:0] prev;
      logic [N-1:0] fell;
      logic [2:0]   e;
      int           n;
      int           irqs;
      pwr_req  = '0;
      auto_ack = 1'b1;
      stuck    = '0;
      do_reset();
      exp_q = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
      prev  = pwr_state;
      n     = 0;
      irqs  = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
         fell = prev & ~pwr_state;
         prev = pwr_state;
         checks++; if ($countones(iso_req & pwr_state) > 1) begin errors++; $display("FAIL all_down_overlap got=%b exp=at most one in flight", iso_req & pwr_state); end
         for (int i = 0; i < N; i++) begin
            if (fell[i]) begin
               e = exp_q.pop_front();
               checks++; if (3'(i) !== e) begin errors++; $display("FAIL all_down_order got=%0d exp=%0d", i, e); end
            end
         end
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
         checks++; if (done_irq !== (fell != '0)) begin errors++; $display("FAIL all_down_irq got=%b exp=%b", done_irq, fell != '0); end
         if (done_irq === 1'b1) begin
            irqs++;
            checks++; if (fell !== (5'b00001 << done_idx)) begin errors++; $display("FAIL all_down_irq_idx got=%0d exp_mask=%b", done_idx, fell); end
         end
`endif
      end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL all_down_timeout got_remaining=%0d exp=0", exp_q.size()); end
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
      checks++; if (irqs != 5) begin errors++; $display("FAIL all_down_irq_count got=%0d exp=5", irqs); end
`endif
      checks++; if (pwr_state !== 5'b00000 || clk_en !== 5'b00000 || iso_req !== 5'b11111 || cluster_rst !== 5'b11111 || busy !== 1'b0) begin
         errors++; $display("FAIL all_down_final got pwr=%b clk=%b iso=%b rst=%b busy=%b exp=00000/00000/11111/11111/0", pwr_state, clk_en, iso_req, cluster_rst, busy);
      end
   endtask

   // Cluster 1 never acks: timeout abort, no retry until err_clr.
   task automatic test_timeout();
      int n;
      int busy_cycles;
      pwr_req  = '1;
      auto_ack = 1'b1;
      stuck    = '0;
      do_reset();
      stuck   = 5'b00010;
      pwr_req = 5'b11101;
      repeat (1000) @(negedge clk);
      checks++; if (err !== 5'b00000 || busy !== 1'b1 || iso_req !== 5'b00010) begin errors++; $display("FAIL timeout_early got err=%b busy=%b iso=%b exp=00000/1/00010", err, busy, iso_req); end
      n = 0;
      while (err[1] !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++; if (err !== 5'b00010) begin errors++; $display("FAIL timeout_err got=%b exp=00010", err); end
      checks++; if (iso_req !== 5'b00000 || pwr_state !== 5'b11111 || clk_en !== 5'b11111 || cluster_rst !== 5'b00000) begin
         errors++; $display("FAIL timeout_restore got iso=%b pwr=%b clk=%b rst=%b exp=00000/11111/11111/00000", iso_req, pwr_state, clk_en, cluster_rst);
      end
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
      checks++; if (done_irq !== 1'b1 || done_idx !== 3'd1) begin errors++; $display("FAIL timeout_irq got=%b/%0d exp=1/1", done_irq, done_idx); end
`endif
      busy_cycles = 0;
      repeat (20) begin
         @(negedge clk);
         if (busy === 1'b1 || iso_req !== 5'b00000) busy_cycles++;
      end
      checks++; if (busy_cycles != 0) begin errors++; $display("FAIL timeout_no_retry got_busy_cycles=%0d exp=0", busy_cycles); end
      stuck   = '0;
      err_clr = 5'b00010;
      @(negedge clk);
      err_clr = '0;
      checks++; if (err !== 5'b00000) begin errors++; $display("FAIL err_clr got=%b exp=00000", err); end
      n = 0;
      while (pwr_state[1] !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++; if (pwr_state !== 5'b11101 || err !== 5'b00000) begin errors++; $display("FAIL retry_after_clr got pwr=%b err=%b exp=11101/00000", pwr_state, err); end
   endtask

   // Request flips back during RST of a cluster-0 power-down.
   task automatic test_mid_toggle();
      int n;
      pwr_req  = '1;
      auto_ack = 1'b1;
      stuck    = '0;
      do_reset();
      pwr_req = 5'b11110;
      n = 0;
      while (cluster_rst[0] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (cluster_rst !== 5'b00001) begin errors++; $display("FAIL toggle_reach_rst got=%b exp=00001", cluster_rst); end
      pwr_req = 5'b11111;
      n = 0;
      while (pwr_state[0] !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++; if (pwr_state !== 5'b11110 || busy !== 1'b0 || clk_en[0] !== 1'b0) begin errors++; $display("FAIL toggle_down_done got pwr=%b busy=%b clk=%b exp=11110/0/xxxx0", pwr_state, busy, clk_en); end
      @(negedge clk);
      checks++; if (clk_en[0] !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL toggle_up_start got clk=%b busy=%b exp=1/1", clk_en[0], busy); end
      n = 0;
      while (pwr_state[0] !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++; if (pwr_state !== 5'b11111 || iso_req !== 5'b00000 || cluster_rst !== 5'b00000 || err !== 5'b00000) begin
         errors++; $display("FAIL toggle_up_done got pwr=%b iso=%b rst=%b err=%b exp=11111/00000/00000/00000", pwr_state, iso_req, cluster_rst, err);
      end
   endtask

   // Reset asserted while cluster 3 is in RST_REL of a power-up.
   task automatic test_reset_mid();
      int n;
      pwr_req = 5'b10111;
      n = 0;
      while (pwr_state[3] !== 1'b0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++; if (pwr_state !== 5'b10111) begin errors++; $display("FAIL rstmid_down got=%b exp=10111", pwr_state); end
      pwr_req = 5'b11111;
      n = 0;
      while (clk_en[3] !== 1'b1 && n < 5) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++; if (cluster_rst !== 5'b01000 || busy !== 1'b1) begin errors++; $display("FAIL rstmid_in_rst_rel got rst=%b busy=%b exp=01000/1", cluster_rst, busy); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (pwr_state !== 5'b11111 || clk_en !== 5'b11111 || iso_req !== 5'b00000 || cluster_rst !== 5'b00000 || err !== 5'b00000 || busy !== 1'b0) begin
         errors++; $display("FAIL rstmid_outputs got pwr=%b clk=%b iso=%b rst=%b err=%b busy=%b exp=11111/11111/00000/00000/00000/0", pwr_state, clk_en, iso_req, cluster_rst, err, busy);
      end
`ifdef CHIMERA_PWR_SEQ_IRQ_EN
      checks++; if (done_irq !== 1'b0 || done_idx !== 3'd0) begin errors++; $display("FAIL rstmid_irq got=%b/%0d exp=0/0", done_irq, done_idx); end
`endif
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0 || pwr_state !== 5'b11111) begin errors++; $display("FAIL rstmid_after got busy=%b pwr=%b exp=0/11111", busy, pwr_state); end
   endtask

   initial begin
      rst      = 1'b1;
      pwr_req  = '1;
      err_clr  = '0;
      auto_ack = 1'b1;
      stuck    = '0;
      man_ack  = '0;
      test_reset();
      test_power_down();
      test_power_up();
      test_all_down();
      test_timeout();
      test_mid_toggle();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/chimera_cluster_pwr_seq.md
Name: chimera_cluster_pwr_seq

Overview:
- Shared power sequencer for the external cluster domain.
- Serialises per-cluster power-down and power-up requests from top-level config regs, driving AXI isolation, clock enable and cluster reset in a fixed order.
- One cluster is sequenced at a time; pending clusters are granted round-robin.
- Sits between the top-level cfg regs and the per-cluster isolation/clock-gate/reset cells; used in the isolate configuration.

Parameters:
- NumClusters, ExtClusters (5), number of sequenced clusters.
- RstCycles, 8, cycles cluster reset is held on each transition (>=1).
- TimeoutCycles, 1024, max cycles waiting on an isolation ack before abort.
- CntWidth, $clog2(TimeoutCycles+1), width of the shared wait counter.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, synchronous active-high reset.
- pwr_req_i, in, NumClusters, desired state per cluster (1=on), level from cfg regs.
- pwr_state_o, out, NumClusters, committed state per cluster (1=on).
- busy_o, out, 1, sequencer not IDLE.
- err_o, out, NumClusters, sticky timeout flag per cluster.
- err_clr_i, in, NumClusters, write-1 pulse clearing err_o bits.
- iso_req_o, out, NumClusters, request AXI isolation.
- iso_ack_i, in, NumClusters, isolation complete, level.
- clk_en_o, out, NumClusters, cluster clock gate enable.
- cluster_rst_o, out, NumClusters, active-high cluster reset.

Behaviour:
- Interface: one clock, clk_i; reset is synchronous and active-high, rst_i. All outputs are registered.
- Reset values:
  - pwr_state_o = all 1; clk_en_o = all 1.
  - iso_req_o = 0; cluster_rst_o = 0; err_o = 0; busy_o = 0.
  - FSM in IDLE, round-robin pointer = 0.
- Eligible cluster: pwr_req_i[c] != pwr_state_o[c] and err_o[c] == 0.
- Pick: round-robin from pointer. After each completion or abort, the pointer moves to cur+1 mod NumClusters.
- IDLE: if any cluster is eligible, latch cur and dir = pwr_req_i[cur], clear the counter, then go to ISO_ON (dir=0) or CLK_ON (dir=1). Pick takes 1 cycle.
- Power-down path:
  - ISO_ON: iso_req_o[cur]=1. Wait for iso_ack_i[cur]. If the counter reaches TimeoutCycles first, go to ABORT.
  - CLK_OFF: clk_en_o[cur]=0, one cycle.
  - RST: cluster_rst_o[cur]=1, hold RstCycles, then DONE.
  - cluster_rst_o and iso_req_o stay asserted while the cluster is off.
- Power-up path:
  - CLK_ON: clk_en_o[cur]=1, one cycle.
  - RST_REL: keep reset asserted RstCycles more, then deassert.
  - ISO_OFF: iso_req_o[cur]=0. Wait for iso_ack_i[cur]=0, with timeout, then DONE.
- DONE: pwr_state_o[cur] = dir, advance pointer, return to IDLE. No-contention latency for power-down = 1 + ack wait + 1 + RstCycles + 1 cycles.
- ABORT (timeout):
  - Set err_o[cur].
  - Restore the cluster to its pre-request state: power-down abort deasserts iso_req_o; power-up abort re-asserts iso_req_o, cluster_rst_o=1, clk_en_o=0.
  - pwr_state_o unchanged; advance pointer; go to IDLE.
- pwr_req_i[cur] changing mid-sequence is ignored. The sequence completes, and the opposite transition becomes eligible afterwards.
- err_clr_i on the same cycle as an ABORT set: the set wins.
- Counter saturates and never wraps.
- rst_i mid-sequence returns all outputs to reset values immediately.

Optional Feature:
- Macro: CHIMERA_PWR_SEQ_IRQ_EN.
- Defined: adds output done_irq_o (1 bit), a single-cycle pulse on every DONE or ABORT exit. Adds output done_idx_o ($clog2(NumClusters) bits), holding the cluster index of the last exit; reset value 0.
- Undefined: both ports are absent; no other behaviour changes.

Decomposition:
- chimera_pkg gets:
  - the pwr_seq_state_e enum (IDLE, ISO_ON, CLK_OFF, RST, CLK_ON, RST_REL, ISO_OFF, DONE, ABORT);
  - localparams PwrSeqRstCycles and PwrSeqTimeoutCycles.
- One sub-module: chimera_pwr_rr_pick, a combinational round-robin pick from an eligible mask and pointer, giving valid and index.

Test Plan:
- Power-down of cluster 2 with ack 3 cycles after iso_req_o[2] -> clk_en_o[2]=0, then cluster_rst_o[2]=1 for 8 cycles, then pwr_state_o[2]=0; busy_o falls the cycle after DONE.
- Power-up of cluster 2 from off -> clk_en_o[2]=1, reset released 8 cycles later, iso_req_o[2]=0; once ack drops, pwr_state_o[2]=1.
- pwr_req_i = 5'b00000 from reset, ack immediate -> clusters powered down in order 0,1,2,3,4, never two busy at once.
- iso_ack_i[1] stuck at 0 -> after 1024 cycles err_o[1]=1, iso_req_o[1]=0, pwr_state_o[1]=1. Cluster 1 is not retried until err_clr_i[1] pulses, then it is re-sequenced.
- Toggle pwr_req_i[0] back to 1 during RST of a cluster-0 power-down -> down completes, then the up sequence starts.
- rst_i asserted during RST_REL -> next cycle all outputs at reset values; with CHIMERA_PWR_SEQ_IRQ_EN defined, done_irq_o pulses once per completion with the correct done_idx_o.
